// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address helper for the L1 line-refill controller.
package cache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int CNT_MSB    = 31;
  localparam int CNT_LSB    = 28;
  localparam int CNT_W      = CNT_MSB - CNT_LSB + 1;
  localparam int WP_W       = $clog2(LINE_WORDS) + 1;
  localparam int LINE_BITS  = LINE_WORDS * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  // Word pointer must hold LINE_WORDS itself, hence the extra bit.
  typedef logic [WP_W-1:0] wp_t;

  function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'(LINE_WORDS - 1);
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_rle_beat_decode.sv
// Combinational RLE beat decoder: turns one beat plus the current word pointer into a
// parallel write mask, the zero-extended payload, the advanced pointer and an error flag.
module rle_beat_decode
  import cache_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] beat,
  input  wp_t                   wp,
  output logic [DATA_WIDTH-1:0] payload,
  output logic [LINE_WORDS-1:0] mask,
  output wp_t                   wp_next,
  output logic                  err
);

  logic [CNT_W-1:0] cnt;
  wp_t              remaining;
  wp_t              run;
  logic             over;

  always_comb begin
    cnt       = beat[CNT_MSB:CNT_LSB];
    payload   = {{CNT_W{1'b0}}, beat[CNT_LSB-1:0]};
    remaining = wp_t'(LINE_WORDS) - wp;
    over      = wp_t'(cnt) > remaining;
    // A run longer than the space left is clipped so the pointer saturates at LINE_WORDS.
    run       = over ? remaining : wp_t'(cnt);
    wp_next   = wp + run;
    err       = (cnt == '0) || over;
    for (int i = 0; i < LINE_WORDS; i++) begin
      mask[i] = (wp_t'(i) >= wp) && (wp_t'(i) < wp_next);
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// L1 line-refill sequencer: accepts one miss, issues the line-aligned read and assembles
// RLE beats into a full line that is returned to the cache in a single-cycle pulse.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  mem_rd_valid,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ready,
  input  logic                  mem_data_valid,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_data_ready,
  output logic                  fill_valid,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [LINE_BITS-1:0]  fill_line,
  output logic                  fill_err
);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]                 base_q;
  wp_t                                   wp_q;
  logic                                  err_q;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_q;

  logic [DATA_WIDTH-1:0] dec_payload;
  logic [LINE_WORDS-1:0] dec_mask;
  wp_t                   dec_wp_next;
  logic                  dec_err;

  logic req_fire;
  logic beat_fire;

  assign req_fire  = req_valid && req_ready;
  assign beat_fire = mem_data_valid && mem_data_ready;

  rle_beat_decode u_decode (
    .beat    (mem_data),
    .wp      (wp_q),
    .payload (dec_payload),
    .mask    (dec_mask),
    .wp_next (dec_wp_next),
    .err     (dec_err)
  );

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = ADDR;
      ADDR: if (mem_rd_ready) state_d = DATA;
      DATA: if (beat_fire && (dec_wp_next == wp_t'(LINE_WORDS))) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    mem_rd_valid   = 1'b0;
    mem_data_ready = 1'b0;
    fill_valid     = 1'b0;
    unique case (state_q)
      IDLE: req_ready      = 1'b1;
      ADDR: mem_rd_valid   = 1'b1;
      DATA: mem_data_ready = 1'b1;
      DONE: fill_valid     = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the line buffer is deliberately reset and re-cleared on every accepted request;
  // a partially filled line must never expose words from an earlier fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      wp_q   <= '0;
      err_q  <= 1'b0;
      line_q <= '0;
    end else if (req_fire) begin
      base_q <= line_base(req_addr);
      wp_q   <= '0;
      err_q  <= 1'b0;
      line_q <= '0;
    end else if (beat_fire) begin
      wp_q <= dec_wp_next;
      if (dec_err) err_q <= 1'b1;
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (dec_mask[i]) line_q[i] <= dec_payload;
      end
    end
  end

  assign mem_rd_addr = base_q;
  assign fill_addr   = base_q;
  assign fill_line   = line_q;
  assign fill_err    = fill_valid && err_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a table of RLE fills plus hand-written
// reset-abort, stall and back-to-back sequences.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_ready;
  logic         mem_rd_valid;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_ready;
  logic         mem_data_valid;
  logic [31:0]  mem_data;
  logic         mem_data_ready;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [255:0] fill_line;
  logic         fill_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_ready   (mem_rd_ready),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data),
    .mem_data_ready (mem_data_ready),
    .fill_valid     (fill_valid),
    .fill_addr      (fill_addr),
    .fill_line      (fill_line),
    .fill_err       (fill_err)
  );

  typedef struct {
    logic [31:0]       addr;
    logic [3:0][31:0]  beats;
    int                nbeats;
    int                rd_delay;
    bit                gaps;
    logic [31:0]       exp_addr;
    logic [7:0][31:0]  exp_line;
    bit                exp_err;
    int                exp_consumed;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [3:0][31:0] beats,
                              input int nbeats, input int rd_delay, input bit gaps,
                              input logic [31:0] exp_addr, input logic [7:0][31:0] exp_line,
                              input bit exp_err, input int exp_consumed);
    vec_t v;
    v.addr         = addr;
    v.beats        = beats;
    v.nbeats       = nbeats;
    v.rd_delay     = rd_delay;
    v.gaps         = gaps;
    v.exp_addr     = exp_addr;
    v.exp_line     = exp_line;
    v.exp_err      = exp_err;
    v.exp_consumed = exp_consumed;
    return v;
  endfunction

  // Called at a negedge while the DUT is IDLE; returns at the negedge of the IDLE cycle
  // that directly follows DONE, so consecutive calls exercise back-to-back requests.
  task automatic run_fill(input vec_t v, input string tag);
    int  idx;
    int  t;
    bit  done;
    check({tag, "_req_ready_idle"}, 256'(req_ready), 256'(1));
    req_valid = 1'b1;
    req_addr  = v.addr;
    @(negedge clk);
    t = 1;
    // While in ADDR, offer a different request and a junk beat; both must be ignored.
    req_addr       = ~v.addr;
    mem_data_valid = 1'b1;
    mem_data       = 32'hF000_BAD0;
    check({tag, "_req_ready_busy"}, 256'(req_ready), 256'(0));
    check({tag, "_data_ready_addr"}, 256'(mem_data_ready), 256'(0));
    for (int s = 0; s <= v.rd_delay; s++) begin
      mem_rd_ready = (s == v.rd_delay);
      check({tag, "_rd_valid"}, 256'(mem_rd_valid), 256'(1));
      check({tag, "_rd_addr"}, 256'(mem_rd_addr), 256'(v.exp_addr));
      @(negedge clk);
      t++;
    end
    mem_rd_ready   = 1'b0;
    req_valid      = 1'b0;
    mem_data_valid = 1'b0;
    check({tag, "_rd_valid_drop"}, 256'(mem_rd_valid), 256'(0));
    idx  = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (fill_valid) begin
        done = 1'b1;
      end else begin
        if (idx < v.nbeats && (!v.gaps || $urandom_range(0, 2) != 0)) begin
          mem_data_valid = 1'b1;
          mem_data       = v.beats[idx];
        end else begin
          mem_data_valid = 1'b0;
          mem_data       = 32'h0;
        end
        if (mem_data_valid && mem_data_ready) idx++;
        @(negedge clk);
        t++;
      end
    end
    if (!done) begin
      check({tag, "_fill_timeout"}, 256'(0), 256'(1));
      mem_data_valid = 1'b0;
      return;
    end
    // Keep offering any leftover beat during DONE; it must not be accepted.
    if (idx < v.nbeats) begin
      mem_data_valid = 1'b1;
      mem_data       = v.beats[idx];
    end
    check({tag, "_data_ready_done"}, 256'(mem_data_ready), 256'(0));
    check({tag, "_fill_line"}, fill_line, v.exp_line);
    check({tag, "_fill_addr"}, 256'(fill_addr), 256'(v.exp_addr));
    check({tag, "_fill_err"}, 256'(fill_err), 256'(v.exp_err));
    check({tag, "_consumed"}, 256'(idx), 256'(v.exp_consumed));
    // Cycle count: request in cycle 0, (rd_delay+1) ADDR cycles, one DATA cycle per beat.
    if (!v.gaps) check({tag, "_latency"}, 256'(t), 256'(1 + (v.rd_delay + 1) + v.exp_consumed));
    @(negedge clk);
    mem_data_valid = 1'b0;
    check({tag, "_single_pulse"}, 256'(fill_valid), 256'(0));
    check({tag, "_ready_after_done"}, 256'(req_ready), 256'(1));
  endtask

  initial begin
    int pulses;

    vecs[0] = mk(32'h0000_1235, {96'h0, 32'h8000_00AA}, 1, 0, 1'b0, 32'h0000_1230,
                 {8{32'h0000_00AA}}, 1'b0, 1);
    vecs[1] = mk(32'hABCD_EF07, {32'h0, 32'h3000_0003, 32'h2000_0002, 32'h3000_0001}, 3, 0, 1'b0,
                 32'hABCD_EF00, {{3{32'h3}}, {2{32'h2}}, {3{32'h1}}}, 1'b0, 3);
    vecs[2] = mk(32'h0000_0008, {32'h0, 32'h1000_00FF, 32'h5000_0007, 32'h6000_0005}, 3, 0, 1'b0,
                 32'h0000_0008, {{2{32'h7}}, {6{32'h5}}}, 1'b1, 2);
    vecs[3] = mk(32'hFFFF_FFFF, {64'h0, 32'h8000_0004, 32'h0000_0009}, 2, 1, 1'b0,
                 32'hFFFF_FFF8, {8{32'h4}}, 1'b1, 2);
    vecs[4] = mk(32'h0000_7777, {96'h0, 32'hFFFF_FFFF}, 1, 0, 1'b0, 32'h0000_7770,
                 {8{32'h0FFF_FFFF}}, 1'b1, 1);
    vecs[5] = mk(32'h1234_567D, {32'h0, 32'h3000_0003, 32'h2000_0002, 32'h3000_0001}, 3, 5, 1'b1,
                 32'h1234_5678, {{3{32'h3}}, {2{32'h2}}, {3{32'h1}}}, 1'b0, 3);
    vecs[6] = mk(32'h0000_0013, {32'h2000_0004, 32'h2000_0003, 32'h2000_0002, 32'h2000_0001}, 4, 0,
                 1'b1, 32'h0000_0010, {{2{32'h4}}, {2{32'h3}}, {2{32'h2}}, {2{32'h1}}}, 1'b0, 4);

    rst            = 1'b1;
    req_valid      = 1'b0;
    req_addr       = 32'h0;
    mem_rd_ready   = 1'b0;
    mem_data_valid = 1'b0;
    mem_data       = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 256'(req_ready), 256'(1));
    check("rst_rd_valid", 256'(mem_rd_valid), 256'(0));
    check("rst_rd_addr", 256'(mem_rd_addr), 256'(0));
    check("rst_data_ready", 256'(mem_data_ready), 256'(0));
    check("rst_fill_valid", 256'(fill_valid), 256'(0));
    check("rst_fill_err", 256'(fill_err), 256'(0));
    check("rst_fill_addr", 256'(fill_addr), 256'(0));
    check("rst_fill_line", fill_line, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_fill(vecs[i], $sformatf("v%0d", i));

    // Reset after two of four beats: fill aborted, partial line discarded.
    req_valid = 1'b1;
    req_addr  = 32'h2000_0010;
    @(negedge clk);
    req_valid    = 1'b0;
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_data_valid = 1'b1;
      mem_data       = (b == 0) ? 32'h2000_0011 : 32'h2000_0022;
      @(negedge clk);
    end
    mem_data_valid = 1'b0;
    check("abort_no_early_fill", 256'(fill_valid), 256'(0));
    rst = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 256'(req_ready), 256'(1));
    check("abort_fill_valid", 256'(fill_valid), 256'(0));
    check("abort_line_cleared", fill_line, 256'(0));
    check("abort_data_ready", 256'(mem_data_ready), 256'(0));
    rst    = 1'b0;
    pulses = 0;
    mem_data_valid = 1'b1;
    mem_data       = 32'h8000_0033;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fill_valid) pulses++;
    end
    mem_data_valid = 1'b0;
    check("abort_no_fill_pulse", 256'(pulses), 256'(0));
    check("abort_still_idle", 256'(req_ready), 256'(1));
    run_fill(vecs[1], "post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
